// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings and decode helpers.
// The hazard unit uses EX_MULDIV_MD_CLASS to find D-stage instructions that must wait on md_stall.
`define EX_MULDIV_MD_CLASS(op_) (((op_) >= 3'd1) && ((op_) <= 3'd6))

package ex_muldiv_pkg;

    localparam int MD_OP_WIDTH = 3;

    typedef enum logic [MD_OP_WIDTH-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    // Ops that occupy the unit for multiple cycles.
    function automatic logic md_is_multicycle(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_md_compute.sv
// Combinational mult/div datapath: produces the {hi,lo} result and a divide-by-zero flag.
// Only the op-selected result is meaningful; the rest of the unit registers it on start.
module md_compute
    import ex_muldiv_pkg::*;
(
    input  logic [MD_OP_WIDTH-1:0] op_i,
    input  logic [31:0]            a_i,
    input  logic [31:0]            b_i,
    output logic [63:0]            result_o,
    output logic                   div_zero_o
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic               div_ovf;
    logic [31:0]        b_safe;
    logic signed [31:0] a_s32;
    logic signed [31:0] b_s32;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;

    // INT_MIN / -1 overflows; its architectural result is fixed, so the divider
    // never sees that pair (nor a zero divisor).
    assign div_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    assign b_safe  = ((b_i == 32'd0) || div_ovf) ? 32'd1 : b_i;

    assign a_sx  = {{32{a_i[31]}}, a_i};
    assign b_sx  = {{32{b_i[31]}}, b_i};
    assign a_s32 = a_i;
    assign b_s32 = b_safe;
    assign quo_s = a_s32 / b_s32;
    assign rem_s = a_s32 % b_s32;
    assign quo_u = a_i / b_safe;
    assign rem_u = a_i % b_safe;

    always_comb begin
        result_o   = 64'd0;
        div_zero_o = 1'b0;
        case (op_i)
            MD_MULT:  result_o = a_sx * b_sx;
            MD_MULTU: result_o = {32'd0, a_i} * {32'd0, b_i};
            MD_DIV: begin
                if (b_i == 32'd0) begin
                    div_zero_o = 1'b1;
                end else if (div_ovf) begin
                    result_o = {32'd0, 32'h8000_0000};
                end else begin
                    result_o = {rem_s, quo_s};
                end
            end
            MD_DIVU: begin
                if (b_i == 32'd0) begin
                    div_zero_o = 1'b1;
                end else begin
                    result_o = {rem_u, quo_u};
                end
            end
            default: result_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: multi-cycle latency counter, pending result, and the
// architectural HI/LO registers. md_stall freezes md-class instructions in D.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [MD_OP_WIDTH-1:0] op,
    input  logic [31:0]            A,
    input  logic [31:0]            B,
    output logic                   busy,
    output logic                   md_stall,
    output logic [31:0]            HI,
    output logic [31:0]            LO
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [63:0]      calc_result;
    logic             calc_div_zero;

    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [31:0]      hi_q,      hi_d;
    logic [31:0]      lo_q,      lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_dz_q, pend_dz_d;
    logic             busy_w;

    md_compute u_md_compute (
        .op_i       (op),
        .a_i        (A),
        .b_i        (B),
        .result_o   (calc_result),
        .div_zero_o (calc_div_zero)
    );

    assign busy_w = (cnt_q != '0);

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;

        if (busy_w) begin
            // Everything arriving while busy (start or mthi/mtlo) is dropped.
            cnt_d = cnt_q - CNT_W'(1);
            if ((cnt_q == CNT_W'(1)) && !pend_dz_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else begin
            if (start && md_is_multicycle(op)) begin
                pend_hi_d = calc_result[63:32];
                pend_lo_d = calc_result[31:0];
                pend_dz_d = calc_div_zero;
                cnt_d     = md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end
            if (op == MD_MTHI) begin
                hi_d = A;
            end
            if (op == MD_MTLO) begin
                lo_d = A;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
        end
    end

    assign busy     = busy_w;
    assign md_stall = start | busy_w;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, hand-written corner sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_ex_muldiv;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests  = 0;
    int failed = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    ex_muldiv #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .md_stall (md_stall),
        .HI       (HI),
        .LO       (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  vop;
        logic [31:0] va;
        logic [31:0] vb;
        int          cyc;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: results from the architectural rules, written with plain integer arithmetic.
    function automatic void model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] hi, inout logic [31:0] lo, output int cyc);
        logic [63:0] p;
        int          q;
        int          r;
        cyc = 0;
        case (mop)
            3'd1: begin
                p  = 64'(longint'(int'(a)) * longint'(int'(b)));
                hi = p[63:32]; lo = p[31:0]; cyc = MULT_N;
            end
            3'd2: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32]; lo = p[31:0]; cyc = MULT_N;
            end
            3'd3: begin
                cyc = DIV_N;
                if (b == 32'd0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'd0;
                end else begin
                    q = int'(a) / int'(b);
                    r = int'(a) % int'(b);
                    lo = q; hi = r;
                end
            end
            3'd4: begin
                cyc = DIV_N;
                if (b != 32'd0) begin
                    lo = a / b; hi = a % b;
                end
            end
            default: cyc = 0;
        endcase
    endfunction

    // Issues one start cycle, counts busy cycles (bounded), then checks HI/LO.
    task automatic run_md(input string name, input logic [2:0] vop, input logic [31:0] va,
                          input logic [31:0] vb, input int ecyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        @(negedge clk);
        start = 1'b1; op = vop; A = va; B = vb;
        #1 chk({name, " md_stall@start"}, 32'(md_stall), 32'd1);
        @(negedge clk);
        start = 1'b0; op = 3'd0; A = $urandom; B = $urandom;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({name, " busy_cycles"}, 32'(n), 32'(ecyc));
        chk({name, " HI"}, HI, ehi);
        chk({name, " LO"}, LO, elo);
    endtask

    task automatic mt(input string name, input logic [2:0] vop, input logic [31:0] v, input logic st);
        @(negedge clk);
        start = st; op = vop; A = v; B = $urandom;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        if (vop == 3'd5) m_hi = v; else m_lo = v;
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " HI"}, HI, m_hi);
        chk({name, " LO"}, LO, m_lo);
    endtask

    initial begin
        int          n;
        int          falls;
        logic        prev;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          ecyc;

        reset = 1'b0; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;

        vecs.push_back('{3'd1, 32'hFFFF_FFFE, 32'd3,        MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,        MULT_N, 32'h0000_0001, 32'hFFFF_FFFE});
        vecs.push_back('{3'd3, 32'hFFFF_FFF9, 32'd2,        DIV_N,  32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{3'd4, 32'd100,       32'd7,        DIV_N,  32'd2,         32'd14});
        vecs.push_back('{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, MULT_N, 32'h3FFF_FFFF, 32'h0000_0001});
        vecs.push_back('{3'd3, 32'd7,         32'hFFFF_FFFE, DIV_N,  32'd1,         32'hFFFF_FFFD});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, MULT_N, 32'h4000_0000, 32'h0000_0000});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{3'd4, 32'hFFFF_FFFF, 32'd1,        DIV_N,  32'd0,         32'hFFFF_FFFF});

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset md_stall", 32'(md_stall), 32'd0);
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_md($sformatf("vec%0d", i), vecs[i].vop, vecs[i].va, vecs[i].vb,
                   vecs[i].cyc, vecs[i].ehi, vecs[i].elo);
            m_hi = vecs[i].ehi; m_lo = vecs[i].elo;
        end

        // Non-multicycle ops with start=1 must not start anything.
        run_md("start_op0", 3'd0, 32'd9, 32'd9, 0, m_hi, m_lo);
        run_md("start_op7", 3'd7, 32'd9, 32'd9, 0, m_hi, m_lo);

        // Divide by zero leaves HI/LO untouched after the full divide latency.
        mt("mthi", 3'd5, 32'h11, 1'b0);
        mt("mtlo", 3'd6, 32'h22, 1'b1);
        run_md("divu_zero", 3'd4, 32'd5, 32'd0, DIV_N, 32'h11, 32'h22);

        // Collision: div and mthi attempts during a mult are dropped.
        model(3'd1, 32'd1234, 32'hFFFF_FF00, m_hi, m_lo, ecyc);
        @(negedge clk);
        start = 1'b1; op = 3'd1; A = 32'd1234; B = 32'hFFFF_FF00;
        @(negedge clk);
        n = 0; falls = 0; prev = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (busy) n++;
            if (prev && !busy) falls++;
            prev = busy;
            case (k)
                0: begin start = 1'b0; op = 3'd0; end
                1: begin start = 1'b1; op = 3'd3; A = 32'd99; B = 32'd4;
                         #1 chk("coll md_stall div", 32'(md_stall), 32'd1); end
                2: begin start = 1'b1; op = 3'd5; A = 32'hDEAD_BEEF;
                         #1 chk("coll md_stall mthi", 32'(md_stall), 32'd1); end
                3: begin start = 1'b0; op = 3'd0; end
                default: ;
            endcase
            @(negedge clk);
        end
        chk("coll busy_cycles", 32'(n), 32'(MULT_N));
        chk("coll busy_falls", 32'(falls), 32'd1);
        chk("coll HI", HI, m_hi);
        chk("coll LO", LO, m_lo);

        // Async reset mid-divide (counter at 4) aborts and discards the pending result.
        mt("pre_rst_hi", 3'd5, 32'hAAAA, 1'b0);
        mt("pre_rst_lo", 3'd6, 32'h5555, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (6) @(negedge clk);
        chk("pre_rst busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst HI", HI, 32'd0);
        chk("rst LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (12) @(negedge clk);
        chk("post_rst HI", HI, 32'd0);
        chk("post_rst LO", LO, 32'd0);
        run_md("post_rst div", 3'd3, 32'd100, 32'd3, DIV_N, 32'd1, 32'd33);
        m_hi = 32'd1; m_lo = 32'd33;

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (rop == 3'd3 && $urandom_range(0, 5) == 0) begin
                ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
            end
            if (rop == 3'd5 || rop == 3'd6) begin
                mt($sformatf("rnd%0d mt", i), rop, ra, 1'($urandom_range(0, 1)));
            end else begin
                model(rop, ra, rb, m_hi, m_lo, ecyc);
                run_md($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, ecyc, m_hi, m_lo);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- EX-stage multiply/divide unit.
- Consumes the forwarded operands and decoded md-op from the ID/EX pipeline register.
- Models multi-cycle latency and owns the architectural HI/LO registers.
- Drives a stall request to the hazard unit so that md-class instructions in D freeze while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- start  input  1  EX-stage instruction is mult/multu/div/divu this cycle.
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved, treated as none.
- A  input  32  rs operand, post-forwarding.
- B  input  32  rt operand, post-forwarding.
- busy  output  1  operation in flight (counter non-zero).
- md_stall  output  1  combinational: start | busy; hazard unit ORs this into the D-stage stall for md-class instrs.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.

Behaviour:
- Reset (reset==0, asynchronous):
  - HI=0, LO=0, counter=0, pending HI/LO=0, busy=0.
  - Aborts any in-flight operation; the pending result is discarded.
- Start acceptance:
  - At a rising edge with start=1, busy=0 and op in 1..4, latch the computed result into pending_hi/pending_lo.
  - Load the counter with MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4).
- Completion:
  - Each rising edge with counter!=0 decrements the counter.
  - On the edge where counter==1: HI<=pending_hi, LO<=pending_lo, counter<=0.
  - busy is therefore high for exactly N cycles after the start edge.
  - New HI/LO are visible in the cycle busy falls.
- start=1 while busy=1: ignored; no state change. The hazard unit guarantees this does not occur; the bench checks it anyway.
- start=1 with op 0, 5, 6 or 7: ignored as a start.
- mthi/mtlo:
  - op 5 with busy=0: HI<=A at the edge, single cycle, no busy.
  - op 6 with busy=0: LO<=A at the edge, single cycle, no busy.
  - Sampled independently of start.
  - Ignored while busy=1.
- Arithmetic:
  - mult: 64-bit signed product of A*B; HI=[63:32], LO=[31:0].
  - multu: unsigned 64-bit product, same HI/LO split.
  - div: LO=signed quotient truncated toward zero; HI=remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (div): LO=0x80000000, HI=0.
  - divu: unsigned quotient in LO, remainder in HI.
  - Divide by zero (B==0, op 3/4): still busy DIV_CYCLES; at completion HI/LO are left unchanged.
- Reads: mfhi/mflo read HI/LO directly. Because md_stall holds them in D until busy=0, no forwarding from pending values is required.
- md_stall: purely combinational, no registered delay; asserted the same cycle start rises.
- Interaction with pipeline bubbles: the ID/EX register zeroes op/start on bubble, so a bubble never starts an operation.

Decomposition:
- Shared package/include holds:
  - the md op encodings (MD_NONE..MD_MTLO);
  - MD_OP_WIDTH=3;
  - a define for the md-class decode used by the hazard unit.
- One natural sub-module: md_compute. It is purely combinational: takes op, A and B; returns the 64-bit {hi,lo} result and a div-by-zero flag.
- ex_muldiv wraps md_compute with the counter and HI/LO state.

Test Plan:
- Reset: reset=0 mid-div (counter=4) -> busy=0, HI=LO=0 immediately; reset=1 then start div -> normal 10-cycle busy.
- mult: A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles, md_stall high from the start cycle; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu: A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div:
  - A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu/zero: preset HI=0x11, LO=0x22 via mthi/mtlo; divu A=5, B=0 -> busy 10 cycles, then HI=0x11, LO=0x22 unchanged.
- Collision: start mult, then assert start div (and mthi) at cycle 2 of busy -> both ignored; the mult result lands at cycle 5; busy falls once.
